// File: rtl/ooo_pkg.sv
// Shared out-of-order core parameters and types: physical register sizing,
// free-list geometry and the modulo pointer increment shared with the ROB.
package ooo_pkg;

  localparam int unsigned PREG_WIDTH = 7;
  localparam int unsigned ARCH_REGS  = 32;
  localparam int unsigned NUM_PREGS  = 2 ** PREG_WIDTH;
  localparam int unsigned FL_DEPTH   = NUM_PREGS - ARCH_REGS;
  localparam int unsigned FL_PTR_W   = $clog2(FL_DEPTH);
  localparam int unsigned FL_CNT_W   = $clog2(FL_DEPTH + 1);

  typedef logic [PREG_WIDTH-1:0] preg_t;
  typedef logic [FL_PTR_W-1:0]   fl_ptr_t;

  // Circular pointer increment for depths that need not be a power of two.
  function automatic int unsigned ptr_inc_mod(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/preg_free_list.sv
// Circular free list of physical registers: speculative allocation at head,
// reclaim at tail on commit, head restored to the committed head on flush.
module preg_free_list
  import ooo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  output logic                  alloc_valid,
  output logic [PREG_WIDTH-1:0] alloc_preg,
  input  logic                  commit_valid,
  input  logic [PREG_WIDTH-1:0] commit_old_preg,
  input  logic                  flush,
  output logic [FL_CNT_W-1:0]   free_count,
  output logic                  underflow_err
);

  localparam logic [FL_CNT_W-1:0] CNT_FULL = FL_CNT_W'(FL_DEPTH);

  preg_t                mem [FL_DEPTH];
  fl_ptr_t              head;
  fl_ptr_t              commit_head;
  fl_ptr_t              tail;
  logic [FL_CNT_W-1:0]  count;

  logic    alloc_fire;
  fl_ptr_t head_inc;
  fl_ptr_t tail_inc;
  fl_ptr_t commit_head_inc;
  fl_ptr_t commit_head_nxt;
  logic    nothing_outstanding;

  assign alloc_valid = reset && (count != '0) && !flush;
  assign alloc_preg  = mem[head];
  assign free_count  = count;
  assign alloc_fire  = alloc_req && alloc_valid;

  assign head_inc        = fl_ptr_t'(ptr_inc_mod(32'(head), FL_DEPTH));
  assign tail_inc        = fl_ptr_t'(ptr_inc_mod(32'(tail), FL_DEPTH));
  assign commit_head_inc = fl_ptr_t'(ptr_inc_mod(32'(commit_head), FL_DEPTH));
  assign commit_head_nxt = commit_valid ? commit_head_inc : commit_head;

  assign nothing_outstanding = (commit_head == head) && (count == CNT_FULL);

  // A commit landing in the same cycle as a flush is folded in before head is restored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= preg_t'(ARCH_REGS + i);
      end
      head          <= '0;
      commit_head   <= '0;
      tail          <= '0;
      count         <= CNT_FULL;
      underflow_err <= 1'b0;
    end else begin
      if (commit_valid) begin
        mem[tail] <= commit_old_preg;
        tail      <= tail_inc;
      end
      commit_head <= commit_head_nxt;

      if (flush) begin
        head  <= commit_head_nxt;
        count <= CNT_FULL;
      end else begin
        if (alloc_fire) begin
          head <= head_inc;
        end
        case ({alloc_fire, commit_valid})
          2'b10:   count <= count - FL_CNT_W'(1);
          2'b01:   count <= count + FL_CNT_W'(1);
          default: count <= count;
        endcase
      end

      if (commit_valid && nothing_outstanding) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Scoreboard bench for preg_free_list: directed stimulus queues expected
// allocations, a negedge monitor checks each granted preg and outstanding uniqueness.
module tb_preg_free_list;
  import ooo_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  alloc_req;
  logic                  alloc_valid;
  logic [PREG_WIDTH-1:0] alloc_preg;
  logic                  commit_valid;
  logic [PREG_WIDTH-1:0] commit_old_preg;
  logic                  flush;
  logic [FL_CNT_W-1:0]   free_count;
  logic                  underflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  preg_t sb_q[$];
  logic  outstanding [NUM_PREGS];

  preg_t free_q[$];
  preg_t out_q[$];

  always #5 clk = ~clk;

  preg_free_list dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_preg      (alloc_preg),
    .commit_valid    (commit_valid),
    .commit_old_preg (commit_old_preg),
    .flush           (flush),
    .free_count      (free_count),
    .underflow_err   (underflow_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every granted preg against the scoreboard and track outstanding pregs.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      for (int i = 0; i < NUM_PREGS; i++) outstanding[i] = 1'b0;
    end else begin
      if (alloc_req && alloc_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_unexpected: got preg %0d, expected no grant (t=%0t)", alloc_preg, $time);
        end else begin
          check("alloc_preg", 32'(alloc_preg), 32'(sb_q.pop_front()));
        end
        check("not_outstanding", 32'(outstanding[alloc_preg]), 32'd0);
        outstanding[alloc_preg] = 1'b1;
      end
      if (flush) begin
        for (int i = 0; i < NUM_PREGS; i++) outstanding[i] = 1'b0;
      end else if (commit_valid) begin
        outstanding[commit_old_preg] = 1'b0;
      end
    end
  end

  task automatic drive(input logic areq, input logic cv, input preg_t old, input logic fl);
    alloc_req       = areq;
    commit_valid    = cv;
    commit_old_preg = old;
    flush           = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("rst_alloc_valid", 32'(alloc_valid), 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic alloc_n(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      sb_q.push_back(preg_t'(first + i));
      @(negedge clk);
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;

    // 1: reset then release
    do_reset();
    @(negedge clk);
    check("t1_alloc_valid", 32'(alloc_valid), 32'd1);
    check("t1_alloc_preg", 32'(alloc_preg), 32'd32);
    check("t1_free_count", 32'(free_count), 32'd96);
    check("t1_underflow", 32'(underflow_err), 32'd0);
    next_cycle();

    // 2: drain the whole list, then a 97th request
    alloc_n(96, 32);
    drive(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("t2_empty_valid", 32'(alloc_valid), 32'd0);
    check("t2_empty_count", 32'(free_count), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t2_after97_valid", 32'(alloc_valid), 32'd0);
    check("t2_after97_count", 32'(free_count), 32'd0);
    next_cycle();

    // 3: commit at empty with a simultaneous request
    drive(1'b1, 1'b1, preg_t'(5), 1'b0);
    @(negedge clk);
    check("t3_no_bypass", 32'(alloc_valid), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("t3_valid", 32'(alloc_valid), 32'd1);
    check("t3_preg", 32'(alloc_preg), 32'd5);
    check("t3_count", 32'(free_count), 32'd1);
    check("t3_underflow", 32'(underflow_err), 32'd0);
    next_cycle();

    // 4: alloc 3, then commit + flush in the same cycle
    do_reset();
    alloc_n(3, 32);
    drive(1'b1, 1'b1, preg_t'(7), 1'b1);
    @(negedge clk);
    check("t4_flush_suppress", 32'(alloc_valid), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("t4_preg", 32'(alloc_preg), 32'd33);
    check("t4_count", 32'(free_count), 32'd96);
    check("t4_valid", 32'(alloc_valid), 32'd1);
    next_cycle();
    alloc_n(95, 33);
    sb_q.push_back(preg_t'(7));
    drive(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("t4_drained", 32'(free_count), 32'd0);
    check("t4_underflow", 32'(underflow_err), 32'd0);
    next_cycle();

    // 5: steady-state alloc+commit across pointer wrap
    do_reset();
    free_q.delete();
    out_q.delete();
    for (int i = 0; i < 96; i++) free_q.push_back(preg_t'(32 + i));
    for (int i = 0; i < 95; i++) begin
      preg_t p;
      p = free_q.pop_front();
      out_q.push_back(p);
      sb_q.push_back(p);
      drive(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      next_cycle();
    end
    for (int i = 0; i < 200; i++) begin
      preg_t p;
      preg_t old;
      p   = free_q.pop_front();
      old = out_q.pop_front();
      sb_q.push_back(p);
      out_q.push_back(p);
      drive(1'b1, 1'b1, old, 1'b0);
      @(negedge clk);
      check("t5_count", 32'(free_count), 32'd1);
      next_cycle();
      free_q.push_back(old);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("t5_final_preg", 32'(alloc_preg), 32'(free_q[0]));
    check("t5_underflow", 32'(underflow_err), 32'd0);
    next_cycle();

    // 6: commit with nothing outstanding sets a sticky error
    do_reset();
    @(negedge clk);
    check("t6_pre", 32'(underflow_err), 32'd0);
    drive(1'b0, 1'b1, preg_t'(40), 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("t6_set", 32'(underflow_err), 32'd1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("t6_sticky", 32'(underflow_err), 32'd1);
    next_cycle();
    do_reset();
    @(negedge clk);
    check("t6_cleared", 32'(underflow_err), 32'd0);
    next_cycle();

    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
